// File: rtl/autoreset_pd_acc.sv
// Multiply-accumulate with masked pattern detect and self-clearing accumulator.
// Latency: inputs registered at edge k, product at k+1, P and AUTORESET_OUT updated at k+2.
// No backpressure: a new A/B/C triple is accepted on every clock.
module autoreset_pd_acc #(
  parameter logic [47:0] MASK         = 48'h0,
  parameter bit          AUTORESET_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [29:0] A_IN,
  input  logic [17:0] B_IN,
  input  logic [47:0] C_IN,
  output logic        AUTORESET_OUT
);

  logic signed [24:0] a_reg;
  logic signed [17:0] b_reg;
  logic        [47:0] c_reg;
  logic        [47:0] m_reg;
  logic        [47:0] p_reg;

  // Qualifiers tracking whether each pipeline stage holds data captured after
  // reset. Without them the all-zero reset state would look like a 0 == 0
  // match on the first edge after release and fire a spurious pulse.
  logic               a_vld;
  logic               m_vld;

  logic signed [42:0] prod;
  logic        [47:0] sum;
  logic               match;
  logic               clear;

  // The upper multiplicand bits do not take part in the product.
  logic               unused_a_hi;
  assign unused_a_hi = ^A_IN[29:25];

  // 25x18 signed product, sign-extended to the accumulator width.
  assign prod = a_reg * b_reg;

  // Compare the adder output, not P, so the flag lines up with the P it describes.
  assign sum   = p_reg + m_reg;
  assign match = m_vld && (((sum ^ c_reg) & ~MASK) == 48'h0);
  assign clear = AUTORESET_EN && AUTORESET_OUT;

  // Stage 1: capture operands and pattern.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_reg <= '0;
      b_reg <= '0;
      c_reg <= '0;
      a_vld <= 1'b0;
    end else begin
      a_reg <= A_IN[24:0];
      b_reg <= B_IN;
      c_reg <= C_IN;
      a_vld <= 1'b1;
    end
  end

  // Stage 2: register the product.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_reg <= '0;
      m_vld <= 1'b0;
    end else begin
      m_reg <= {{5{prod[42]}}, prod};
      m_vld <= a_vld;
    end
  end

  // Stage 3: accumulate and detect; a match clears P on the following edge and the
  // product arriving on that edge is dropped.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_reg         <= '0;
      AUTORESET_OUT <= 1'b0;
    end else if (clear) begin
      p_reg         <= '0;
      AUTORESET_OUT <= 1'b0;
    end else begin
      p_reg         <= sum;
      AUTORESET_OUT <= match;
    end
  end

endmodule

// File: tb/tb_autoreset_pd_acc.sv
module tb_autoreset_pd_acc;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [29:0] a_in = '0;
  logic [17:0] b_in = '0;
  logic [47:0] c_in = '0;
  logic        flag_d;
  logic        flag_m;
  logic        flag_n;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // Default parameters: full compare, auto-reset enabled.
  autoreset_pd_acc dut (
    .CLK(CLK), .RST(RST), .A_IN(a_in), .B_IN(b_in), .C_IN(c_in), .AUTORESET_OUT(flag_d)
  );

  // Low four bits excluded from the compare.
  autoreset_pd_acc #(.MASK(48'hF), .AUTORESET_EN(1'b1)) dut_m (
    .CLK(CLK), .RST(RST), .A_IN(a_in), .B_IN(b_in), .C_IN(c_in), .AUTORESET_OUT(flag_m)
  );

  // Detect only, never clears.
  autoreset_pd_acc #(.MASK(48'h0), .AUTORESET_EN(1'b0)) dut_n (
    .CLK(CLK), .RST(RST), .A_IN(a_in), .B_IN(b_in), .C_IN(c_in), .AUTORESET_OUT(flag_n)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold reset for two edges with the given inputs, then release; the next posedge is edge 0.
  task automatic start(input logic [29:0] a, input logic [17:0] b, input logic [47:0] c);
    RST  = 1'b0;
    a_in = a;
    b_in = b;
    c_in = c;
    tick();
    tick();
    RST = 1'b1;
  endtask

  initial begin
    logic [47:0] exp_p;
    logic        exp_f;
    int          ph;

    #2;
    // 1: reset held with live inputs keeps everything at zero.
    RST  = 1'b0;
    a_in = 30'h3E00_0005;   // upper bits set, [24:0] = 5
    b_in = 18'd4;
    c_in = 48'd100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_flag_%0d", i), {47'b0, flag_d}, 48'd0);
      chk($sformatf("rst_p_%0d", i), dut.p_reg, 48'd0);
    end
    RST = 1'b1;

    // 2: 5*4 accumulates toward 100, clears, repeats every 6 edges.
    for (int e = 0; e <= 13; e++) begin
      tick();
      if (e < 2) begin
        exp_p = 48'd0;
        exp_f = 1'b0;
      end else begin
        ph    = (e - 2) % 6;
        exp_p = (ph == 5) ? 48'd0 : 48'(20 * (ph + 1));
        exp_f = (ph == 4);
      end
      chk($sformatf("cnt_p_e%0d", e), dut.p_reg, exp_p);
      chk($sformatf("cnt_f_e%0d", e), {47'b0, flag_d}, {47'b0, exp_f});
    end

    // 3: product equals the pattern, flag alternates.
    start(30'd20, 18'd5, 48'd100);
    for (int e = 0; e <= 7; e++) begin
      tick();
      if (e < 2) begin
        exp_p = 48'd0;
        exp_f = 1'b0;
      end else begin
        exp_f = ((e - 2) % 2) == 0;
        exp_p = exp_f ? 48'd100 : 48'd0;
      end
      chk($sformatf("alt_p_e%0d", e), dut.p_reg, exp_p);
      chk($sformatf("alt_f_e%0d", e), {47'b0, flag_d}, {47'b0, exp_f});
    end

    // 4: overshoot, 196 steps past 100 with no detect.
    start(30'd14, 18'd14, 48'd100);
    for (int e = 0; e <= 9; e++) begin
      tick();
      exp_p = (e < 1) ? 48'd0 : 48'(196 * (e - 1));
      chk($sformatf("ovr_p_e%0d", e), dut.p_reg, exp_p);
      chk($sformatf("ovr_f_e%0d", e), {47'b0, flag_d}, 48'd0);
    end

    // 4b: negative product (-1 * 3) wraps modulo 2^48.
    start(30'h01FF_FFFF, 18'd3, 48'd0);
    tick();
    tick();
    tick();
    chk("wrap_p_e2", dut.p_reg, 48'hFFFF_FFFF_FFFD);
    tick();
    chk("wrap_p_e3", dut.p_reg, 48'hFFFF_FFFF_FFFA);
    chk("wrap_f_e3", {47'b0, flag_d}, 48'd0);

    // 5: masked compare, matches when P reaches 16, period 17 edges.
    start(30'd1, 18'd1, 48'd16);
    for (int e = 0; e <= 36; e++) begin
      tick();
      if (e < 2) begin
        exp_p = 48'd0;
        exp_f = 1'b0;
      end else begin
        ph    = (e - 2) % 17;
        exp_p = (ph == 16) ? 48'd0 : 48'(ph + 1);
        exp_f = (ph == 15);
      end
      chk($sformatf("msk_p_e%0d", e), dut_m.p_reg, exp_p);
      chk($sformatf("msk_f_e%0d", e), {47'b0, flag_m}, {47'b0, exp_f});
    end

    // 6: all zero; detect-only holds high, auto-reset instance alternates.
    start(30'd0, 18'd0, 48'd0);
    for (int e = 0; e <= 5; e++) begin
      tick();
      chk($sformatf("n_f_e%0d", e), {47'b0, flag_n}, (e >= 2) ? 48'd1 : 48'd0);
      chk($sformatf("n_p_e%0d", e), dut_n.p_reg, 48'd0);
      if (e >= 2)
        chk($sformatf("z_f_e%0d", e), {47'b0, flag_d}, (e % 2 == 0) ? 48'd1 : 48'd0);
    end
    // Mid-run reset drops the flag without waiting for a clock.
    RST = 1'b0;
    #1;
    chk("n_async_drop", {47'b0, flag_n}, 48'd0);
    tick();
    chk("n_in_rst", {47'b0, flag_n}, 48'd0);
    tick();
    RST = 1'b1;
    for (int e = 0; e <= 3; e++) begin
      tick();
      chk($sformatf("n_rel_f_e%0d", e), {47'b0, flag_n}, (e >= 2) ? 48'd1 : 48'd0);
    end

    // Pattern change: registered C takes effect on the next compare.
    start(30'd5, 18'd4, 48'd60);
    tick();
    tick();
    tick();
    c_in = 48'd40;        // registered at edge 3, too late for the sum of 40 at edge 3
    tick();
    chk("cchg_p_e3", dut.p_reg, 48'd40);
    chk("cchg_f_e3", {47'b0, flag_d}, 48'd0);
    tick();
    chk("cchg_p_e4", dut.p_reg, 48'd60);
    chk("cchg_f_e4", {47'b0, flag_d}, 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/autoreset_pd_acc.md
Name: autoreset_pd_acc

Overview:
Pipelined multiply-accumulate block with pattern detect and auto-reset, modelled on the DSP48E AUTORESET_PATDET = RESET_MATCH mode. Each cycle it computes P <= P + A*B. P is compared against pattern C under a mask. A match raises AUTORESET_OUT for one cycle and clears the accumulator on the following cycle. It sits in the DSP48E application examples as a self-clearing counter/threshold detector.

Parameters:
- MASK, 48'h0, per-bit ignore mask for the compare; a 1 excludes that bit, so the default compares all 48 bits.
- AUTORESET_EN, 1, 1 = clear P on the cycle after a match; 0 = detect only, never clear.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-low reset; clears all registers.
- A_IN  input  30  multiplicand, signed; only bits [24:0] are used, bits [29:25] are ignored.
- B_IN  input  18  multiplier, signed two's complement.
- C_IN  input  48  pattern value compared against the accumulator.
- AUTORESET_OUT  output  1  registered pattern-detect flag, high for one cycle per match.

Behaviour:
- Clocking and reset: single clock domain. RST=0 asynchronously clears A_reg, B_reg, C_reg, M_reg, P and AUTORESET_OUT to 0.
- Stage 1 (input registers): A_reg <= A_IN[24:0]; B_reg <= B_IN; C_reg <= C_IN.
- Stage 2 (product register): M_reg <= signed A_reg * signed B_reg.
  - Product is 43 bits, sign-extended to 48 bits.
- Stage 3 (accumulator register):
  - If AUTORESET_EN and AUTORESET_OUT==1: P <= 0 and AUTORESET_OUT <= 0. M_reg is discarded that cycle and not added.
  - Otherwise: sum = P + M_reg (modulo 2^48, wrap-around with no saturation); P <= sum; AUTORESET_OUT <= ((sum ^ C_reg) & ~MASK) == 0.
- Pattern compare: uses the adder output, so the flag is aligned with the P value that matched.
- Latency: input at edge k; product registered at edge k+1; P and AUTORESET_OUT updated at edge k+2.
- Auto-reset cycle: pulse width exactly one clock when AUTORESET_EN=1. P is 0 after the clear edge, and accumulation resumes from 0 on the next edge.
- With AUTORESET_EN=0: AUTORESET_OUT stays high on every cycle the sum matches, and P never clears.
- Match after clear: P=0 after a clear is not compared. A match needs a fresh sum, so 0+0 with C=0 matches again on the next cycle.
- Overshoot: if the sum steps past C without equality, there is no detect. P keeps accumulating and wraps at 2^48.
- Changing C_IN: takes effect for compares 1 cycle after it is registered.
- Reset mid-operation: asserting RST clears the pipeline immediately. After RST returns high, the first valid sum appears 2 edges after the first input edge.
- Intended size: plain synthesizable RTL, no vendor primitives.

Test Plan:
1. Reset: hold RST=0 with A=5, B=4 -> AUTORESET_OUT=0 and P=0 throughout; release -> no spurious pulse on the first edge.
2. Constant A=5, B=4, C=100, MASK=0, starting at edge 0 -> P=20,40,60,80,100 after edges 2..6. AUTORESET_OUT=1 only after edge 6. P=0 after edge 7; next pulse after edge 12 (period 6 edges).
3. A=20, B=5, C=100 -> P=100 after edge 2 with pulse. P=0 after edge 3, 100 after edge 4 with pulse; the flag alternates 1/0.
4. A=14, B=14, C=100 -> sums 196, 392, ... never equal C -> AUTORESET_OUT stays 0. P wraps modulo 2^48 without error.
5. MASK=48'hF (low 4 bits ignored), A=1, B=1, C=16 -> first pulse when P=16; P clears and repeats every 17 edges.
6. AUTORESET_EN=0, A=0, B=0, C=0 -> AUTORESET_OUT=1 continuously from edge 2. Pulse RST low mid-run -> output drops to 0 asynchronously, then re-asserts 2 edges after release.
